// File: rtl/store_queue_ctrl.sv
// Store queue controller: buffers CPU stores in a small FIFO and arbitrates
// the single data-memory port between queued stores and CPU loads.
module store_queue_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      st_req,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [31:0]               st_data,
  input  logic [3:0]                st_be,
  output logic                      st_ready,
  input  logic                      ld_req,
  input  logic [ADDR_W-1:0]         ld_addr,
  output logic                      ld_grant,
  output logic                      ld_stall,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-3:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_be,
  output logic                      sq_empty,
  output logic [$clog2(DEPTH):0]    sq_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned WA = ADDR_W - 2;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_LOAD,
    OP_DRAIN
  } op_e;

  logic [WA-1:0] ent_addr_q [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [3:0]    ent_be_q   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic full;
  logic hz;
  logic push;
  logic pop;
  op_e  op;

  assign full = (count_q == (PW+1)'(DEPTH));

  // Load-vs-store alias check against entries held at the start of the cycle
  always_comb begin
    hz = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // entry i is occupied when its distance from head is below count
      if (({1'b0, PW'(PW'(i) - head_q)} < count_q) &&
          (ent_addr_q[i] == ld_addr[ADDR_W-1:2])) begin
        hz = 1'b1;
      end
    end
    hz = hz & ld_req;
  end

  // Port arbitration: full queue forces a drain, else loads win unless aliased
  always_comb begin
    if (!rst_n)                op = OP_IDLE;
    else if (full)             op = OP_DRAIN;
    else if (ld_req && !hz)    op = OP_LOAD;
    else if (count_q != '0)    op = OP_DRAIN;
    else                       op = OP_IDLE;
  end

  // Output decode from the selected port operation
  always_comb begin
    st_ready  = rst_n & ~full;
    sq_count  = rst_n ? count_q : '0;
    sq_empty  = ~rst_n | (count_q == '0);
    ld_grant  = 1'b0;
    ld_stall  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (op)
      OP_LOAD: begin
        mem_en   = 1'b1;
        mem_addr = ld_addr[ADDR_W-1:2];
        ld_grant = 1'b1;
      end
      OP_DRAIN: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ent_addr_q[head_q];
        mem_wdata = ent_data_q[head_q];
        mem_be    = ent_be_q[head_q];
        ld_stall  = ld_req;
      end
      default: ;
    endcase
  end

  // Queue pointer and occupancy next-state; empty byte-enable stores are dropped
  always_comb begin
    push    = st_req & st_ready & (st_be != '0);
    pop     = (op == OP_DRAIN);
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  // Pointer/count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage written at the tail on an accepted store
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= st_addr[ADDR_W-1:2];
      ent_data_q[tail_q] <= st_data;
      ent_be_q[tail_q]   <= st_be;
    end
  end

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Bench for store_queue_ctrl: scoreboard of accepted stores checked against
// memory writes, a per-cycle arbitration model, and directed scenarios.
module tb_store_queue_ctrl;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [3:0]  st_be = '0;
  logic        st_ready;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_grant;
  logic        ld_stall;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        sq_empty;
  logic [2:0]  sq_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t sb[$];

  store_queue_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .st_ready(st_ready),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant), .ld_stall(ld_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .sq_empty(sq_empty), .sq_count(sq_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle reference: arbitration, occupancy and in-order write data
  always @(negedge clk) begin
    bit          hzm;
    logic        e_grant;
    logic        e_we;
    int          n;
    ent_t        e;
    n   = sb.size();
    hzm = 1'b0;
    foreach (sb[i]) if (sb[i].a == ld_addr[31:2]) hzm = 1'b1;
    e_grant = rst_n && ld_req && (n != DEPTH) && !hzm;
    e_we    = rst_n && !e_grant && (n != 0);
    check_eq("m_grant", 64'(ld_grant), 64'(e_grant));
    check_eq("m_stall", 64'(ld_stall), 64'(rst_n && ld_req && !e_grant));
    check_eq("m_en", 64'(mem_en), 64'(e_grant || e_we));
    check_eq("m_we", 64'(mem_we), 64'(e_we));
    check_eq("m_ready", 64'(st_ready), 64'(rst_n && (n != DEPTH)));
    check_eq("m_count", 64'(sq_count), rst_n ? 64'(n) : 64'(0));
    check_eq("m_empty", 64'(sq_empty), 64'(!rst_n || (n == 0)));
    if (e_grant) begin
      check_eq("m_ld_addr", 64'(mem_addr), 64'(ld_addr[31:2]));
      check_eq("m_ld_be", 64'(mem_be), 64'(0));
    end
    if (e_we && n > 0) begin
      e = sb.pop_front();
      check_eq("m_wr_addr", 64'(mem_addr), 64'(e.a));
      check_eq("m_wr_data_be", 64'({mem_wdata, mem_be}), 64'({e.d, e.be}));
    end
    if (!rst_n) sb.delete();
    else if (st_req && (n != DEPTH) && (st_be != 4'b0000))
      sb.push_back({st_addr[31:2], st_data, st_be});
  end

  task automatic cyc(input logic r, input logic sr, input logic [31:0] sa,
                     input logic [31:0] sd, input logic [3:0] sbe,
                     input logic lr, input logic [31:0] la);
    @(posedge clk);
    #1;
    rst_n = r; st_req = sr; st_addr = sa; st_data = sd; st_be = sbe;
    ld_req = lr; ld_addr = la;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic drain_all();
    int k;
    k = 0;
    while (sq_empty !== 1'b1 && k < 20) begin
      idle();
      k++;
    end
    check_eq("drain_done", 64'(sq_empty), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held with a store request pending
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 32'h10, 32'h1234, 4'hF, 1'b0, 32'h0);
      check_eq("rst_ready", 64'(st_ready), 64'(0));
      check_eq("rst_mem_en", 64'(mem_en), 64'(0));
      check_eq("rst_empty", 64'(sq_empty), 64'(1));
    end
    idle();
    check_eq("rel_count", 64'(sq_count), 64'(0));
    check_eq("rel_ready", 64'(st_ready), 64'(1));

    // single sb
    cyc(1'b1, 1'b1, 32'h104, 32'h00AB0000, 4'b0100, 1'b0, 32'h0);
    idle();
    check_eq("sb_we", 64'(mem_we), 64'(1));
    check_eq("sb_addr", 64'(mem_addr), 64'h41);
    check_eq("sb_data", 64'(mem_wdata), 64'h00AB0000);
    check_eq("sb_be", 64'(mem_be), 64'b0100);
    idle();
    check_eq("sb_empty", 64'(sq_empty), 64'(1));

    // load priority over queued stores
    cyc(1'b1, 1'b1, 32'h200, 32'hA0A0A0A0, 4'hF, 1'b1, 32'h400);
    cyc(1'b1, 1'b1, 32'h204, 32'hB1B1B1B1, 4'hF, 1'b1, 32'h400);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h300);
    check_eq("lp_grant", 64'(ld_grant), 64'(1));
    check_eq("lp_we", 64'(mem_we), 64'(0));
    check_eq("lp_addr", 64'(mem_addr), 64'hC0);
    check_eq("lp_count", 64'(sq_count), 64'(2));
    idle();
    check_eq("lp_drain0", 64'(mem_addr), 64'h80);
    idle();
    check_eq("lp_drain1", 64'(mem_addr), 64'h81);
    drain_all();

    // aliasing load stalls until the matching entry retires
    cyc(1'b1, 1'b1, 32'h500, 32'h11111111, 4'hF, 1'b1, 32'h400);
    cyc(1'b1, 1'b1, 32'h200, 32'h22222222, 4'hF, 1'b1, 32'h400);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h202);
    check_eq("hz_stall0", 64'(ld_stall), 64'(1));
    check_eq("hz_addr0", 64'(mem_addr), 64'h140);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h202);
    check_eq("hz_stall1", 64'(ld_stall), 64'(1));
    check_eq("hz_addr1", 64'(mem_addr), 64'h80);
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h202);
    check_eq("hz_grant", 64'(ld_grant), 64'(1));
    check_eq("hz_gcount", 64'(sq_count), 64'(0));
    idle();

    // full queue forces a drain
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 32'h1000 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF, 1'b1, 32'h400);
      check_eq("fl_grant", 64'(ld_grant), 64'(1));
    end
    cyc(1'b1, 1'b1, 32'h1010, 32'hC0DE0004, 4'hF, 1'b1, 32'h400);
    check_eq("fl_ready", 64'(st_ready), 64'(0));
    check_eq("fl_stall", 64'(ld_stall), 64'(1));
    check_eq("fl_addr", 64'(mem_addr), 64'h400);
    cyc(1'b1, 1'b1, 32'h1010, 32'hC0DE0004, 4'hF, 1'b1, 32'h400);
    check_eq("fl_ready2", 64'(st_ready), 64'(1));
    check_eq("fl_grant2", 64'(ld_grant), 64'(1));
    drain_all();

    // empty byte-enable store: accepted, no entry
    cyc(1'b1, 1'b1, 32'h700, 32'hDEADBEEF, 4'h0, 1'b0, 32'h0);
    check_eq("be0_ready", 64'(st_ready), 64'(1));
    idle();
    check_eq("be0_count", 64'(sq_count), 64'(0));
    check_eq("be0_mem_en", 64'(mem_en), 64'(0));

    // same-word store and load on empty queue: load first, store next cycle
    cyc(1'b1, 1'b1, 32'h600, 32'h55AA55AA, 4'hF, 1'b1, 32'h600);
    check_eq("sl_grant", 64'(ld_grant), 64'(1));
    idle();
    check_eq("sl_we", 64'(mem_we), 64'(1));
    check_eq("sl_addr", 64'(mem_addr), 64'h180);
    idle();

    // reset with entries pending discards them
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 1'b1, 32'h2000 + 32'(4 * k), 32'hF00D0000 + 32'(k), 4'hF, 1'b1, 32'h400);
    check_eq("rm_count", 64'(sq_count), 64'(2));
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    check_eq("rm_mem_en", 64'(mem_en), 64'(0));
    idle();
    check_eq("rm_count0", 64'(sq_count), 64'(0));
    check_eq("rm_we", 64'(mem_we), 64'(0));
    idle();
    check_eq("rm_we2", 64'(mem_we), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
